// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU/system side and mem_responder:
// CPU memory port, preload stream, and result dump stream.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic [15:0]           mem_value_i;
  logic                  mem_enable_i;
  logic                  mem_rd_en_i;
  logic                  mem_wr_en_i;
  logic [15:0]           mem_value_o;
  logic                  load_valid_i;
  logic [15:0]           load_data_i;
  logic                  load_last_i;
  logic                  load_ready_o;
  logic                  cpu_run_o;
  logic                  end_program_i;
  logic                  dump_valid_o;
  logic [ADDR_WIDTH-1:0] dump_addr_o;
  logic [15:0]           dump_data_o;
  logic                  dump_ready_i;
  logic                  dump_done_o;
  logic                  err_o;

  modport slave (
    input  mem_addr_i,
    input  mem_value_i,
    input  mem_enable_i,
    input  mem_rd_en_i,
    input  mem_wr_en_i,
    output mem_value_o,
    input  load_valid_i,
    input  load_data_i,
    input  load_last_i,
    output load_ready_o,
    output cpu_run_o,
    input  end_program_i,
    output dump_valid_o,
    output dump_addr_o,
    output dump_data_o,
    input  dump_ready_i,
    output dump_done_o,
    output err_o
  );

  modport master (
    output mem_addr_i,
    output mem_value_i,
    output mem_enable_i,
    output mem_rd_en_i,
    output mem_wr_en_i,
    input  mem_value_o,
    output load_valid_i,
    output load_data_i,
    output load_last_i,
    input  load_ready_o,
    input  cpu_run_o,
    output end_program_i,
    input  dump_valid_o,
    input  dump_addr_o,
    input  dump_data_o,
    output dump_ready_i,
    input  dump_done_o,
    input  err_o
  );
endinterface

// File: rtl/mem_responder.sv
// Target-side word RAM for the CPU memory port: preloads from a
// stream, runs the CPU, then dumps a result window out.
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam addr_t BASE   = addr_t'(DUMP_BASE);
  localparam addr_t TOP    = addr_t'(DEPTH - 1);
  localparam cnt_t  NWORDS = cnt_t'(DUMP_WORDS);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_VLD,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  addr_t       lptr_q, lptr_d;
  addr_t       dptr_q, dptr_d;
  cnt_t        cnt_q, cnt_d;
  logic        rdy_q, rdy_d;
  logic [15:0] rdata_q, rdata_d;
  addr_t       daddr_q, daddr_d;
  logic [15:0] ddata_q, ddata_d;
  logic        err_q, err_d;

  logic [15:0] ram_q [DEPTH];
  logic        ram_we;
  addr_t       ram_waddr;
  logic [15:0] ram_wdata;

  logic strobe;
  logic cpu_wr;
  logic cpu_rd;
  logic load_hs;

  assign strobe  = bus.mem_enable_i
                 & (bus.mem_rd_en_i | bus.mem_wr_en_i);
  assign cpu_wr  = bus.mem_enable_i & bus.mem_wr_en_i;
  assign cpu_rd  = bus.mem_enable_i & bus.mem_rd_en_i;
  assign load_hs = bus.load_valid_i & rdy_q;

  // Single write port; RAM is deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_LOAD;
      lptr_q  <= '0;
      dptr_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      rdata_q <= '0;
      daddr_q <= '0;
      ddata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lptr_q  <= lptr_d;
      dptr_q  <= dptr_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, RAM port steering and error tracking
  always_comb begin
    state_d   = state_q;
    lptr_d    = lptr_q;
    dptr_d    = dptr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    daddr_d   = daddr_q;
    ddata_d   = ddata_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_waddr = lptr_q;
    ram_wdata = bus.load_data_i;

    unique case (state_q)
      S_LOAD: begin
        if (load_hs) begin
          ram_we = 1'b1;
          lptr_d = lptr_q + 1'b1;
          if (bus.load_last_i || lptr_q == TOP) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cpu_wr) begin
          ram_we    = 1'b1;
          ram_waddr = bus.mem_addr_i;
          ram_wdata = bus.mem_value_i;
        end
        // A read colliding with a write loses and is flagged
        if (cpu_rd) begin
          if (bus.mem_wr_en_i) begin
            err_d = 1'b1;
          end else begin
            rdata_d = ram_q[bus.mem_addr_i];
          end
        end
        if (bus.end_program_i) begin
          state_d = S_DUMP_RD;
          dptr_d  = BASE;
          cnt_d   = '0;
        end
      end
      S_DUMP_RD: begin
        ddata_d = ram_q[dptr_q];
        daddr_d = dptr_q;
        state_d = S_DUMP_VLD;
      end
      S_DUMP_VLD: begin
        if (bus.dump_ready_i) begin
          cnt_d  = cnt_q + 1'b1;
          dptr_d = dptr_q + 1'b1;
          if (cnt_q + 1'b1 == NWORDS) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DUMP_RD;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase

    // CPU should be quiet outside RUN; the end-of-program
    // edge itself is tolerated
    if (strobe && state_q != S_RUN && !bus.end_program_i) begin
      err_d = 1'b1;
    end

    rdy_d = (state_d == S_LOAD);
  end

  assign bus.mem_value_o  = rdata_q;
  assign bus.load_ready_o = rdy_q;
  assign bus.cpu_run_o    = (state_q == S_RUN);
  assign bus.dump_valid_o = (state_q == S_DUMP_VLD);
  assign bus.dump_addr_o  = daddr_q;
  assign bus.dump_data_o  = ddata_q;
  assign bus.dump_done_o  = (state_q == S_DONE);
  assign bus.err_o        = err_q;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target-side memory for the CPU's single 16-bit memory port. It answers the CPU's read/write/enable strobes from a synchronous word RAM.
- Before the CPU runs, it preloads the RAM from a streaming load port. It then holds the CPU in reset until loading completes.
- On end of program, it streams a configurable result window out through a dump port.
- It sits beside the cpu top in the system/testbench top and replaces the behavioural memory model.

Parameters:
- ADDR_WIDTH, 8, word-address width; RAM depth = 2**ADDR_WIDTH words of 16 bits.
- DUMP_BASE, 0, first word address streamed out in dump.
- DUMP_WORDS, 16, number of words dumped; range 1..2**ADDR_WIDTH; the address wraps modulo depth.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- mem_addr_i  in  ADDR_WIDTH  CPU word address.
- mem_value_i  in  16  CPU write data.
- mem_enable_i  in  1  CPU access qualifier.
- mem_rd_en_i  in  1  CPU read strobe.
- mem_wr_en_i  in  1  CPU write strobe.
- mem_value_o  out  16  read data to CPU.
- load_valid_i  in  1  load word valid.
- load_data_i  in  16  load word.
- load_last_i  in  1  marks final load word.
- load_ready_o  out  1  load port ready.
- cpu_run_o  out  1  high = CPU released from reset.
- end_program_i  in  1  CPU end-of-program flag.
- dump_valid_o  out  1  dump word valid.
- dump_addr_o  out  ADDR_WIDTH  address of dump word.
- dump_data_o  out  16  dump word.
- dump_ready_i  in  1  dump sink ready.
- dump_done_o  out  1  dump finished (sticky).
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i=0, async): state=LOAD, load pointer=0, dump pointer=0.
- All outputs are 0 during reset except load_ready_o. load_ready_o is 0 while in reset and 1 from the first clock edge after release.
- RAM contents are not reset.
- States: LOAD, RUN, DUMP_RD, DUMP_VLD, DONE.
- LOAD:
  - load_ready_o=1.
  - On load_valid_i&load_ready_o, write load_data_i to RAM[ptr] and increment ptr.
  - Go to RUN after the handshake with load_last_i=1, or after the handshake that writes address 2**ADDR_WIDTH-1.
  - CPU strobes are ignored in LOAD and set err_o.
- RUN:
  - cpu_run_o=1 and load_ready_o=0.
  - Write: on an edge with mem_enable_i&mem_wr_en_i, RAM[mem_addr_i]<=mem_value_i.
  - Read: on an edge with mem_enable_i&mem_rd_en_i, mem_value_o<=RAM[mem_addr_i]. Latency is exactly 1 cycle.
  - mem_value_o holds its value until the next read.
  - rd and wr asserted together: the write is performed, the read is suppressed (mem_value_o holds) and err_o is set.
  - Strobes with mem_enable_i=0 are ignored with no error.
  - A load_valid_i in RUN is ignored.
  - end_program_i=1 at an edge: any access in that same cycle still completes, cpu_run_o drops next cycle, state goes to DUMP_RD, dump pointer=DUMP_BASE, count=0.
- DUMP_RD: one cycle; RAM[ptr] is registered into dump_data_o and ptr into dump_addr_o; state goes to DUMP_VLD.
- DUMP_VLD:
  - dump_valid_o=1; data and address are held stable until dump_ready_i=1.
  - On the handshake: count++, ptr wraps modulo depth.
  - If count reaches DUMP_WORDS, go to DONE; otherwise go to DUMP_RD.
  - Result: one bubble cycle between words; throughput is 1 word per 2 cycles at best.
- DONE: dump_done_o=1 and dump_valid_o=0. The state persists until reset.
- CPU strobes in any state other than RUN set err_o. The exception is the edge on which end_program_i is sampled.
- Reset mid-operation (any state) aborts immediately to LOAD. A partial dump is abandoned; RAM keeps its contents.

Test Plan:
- Load 3 words 0x1111,0x2222,0x3333 (last on 3rd) -> cpu_run_o=1 the cycle after the 3rd handshake. Then read addr 1 -> mem_value_o=0x2222 exactly one cycle later.
- RUN: write 0xBEEF to addr 0x10, read 0x10 on the next cycle -> 0xBEEF. Read with mem_enable_i=0 -> mem_value_o unchanged, err_o=0.
- Simultaneous rd+wr to addr 5 with data 0x0A0A -> RAM[5]=0x0A0A, mem_value_o unchanged, err_o=1 and sticky.
- Load 256 words with no load_last_i (ADDR_WIDTH=8) -> RUN is entered after word 255. A further load_valid_i is ignored.
- DUMP_BASE=254, DUMP_WORDS=4, end_program_i, dump_ready_i toggling -> dump addresses 254,255,0,1 in order, data stable while not ready, then dump_done_o=1.
- Assert rst_i=0 during DUMP_VLD -> all outputs 0 immediately, state LOAD. After release, reading a previously loaded word via a new load of 1 word then RUN returns the old RAM contents at the other addresses.
